// File: rtl/composite_pkg.sv
// Shared constants for the composite encoder: YIQ coefficients, levels, defaults.
// Pipeline depth depends on COMPOSITE_CHROMA_FILTER_EN.
package composite_pkg;

  // YIQ matrix, magnitudes only; signs are applied where the sums are formed
  localparam int K_YR = 77;
  localparam int K_YG = 150;
  localparam int K_YB = 29;
  localparam int K_IR = 153;
  localparam int K_IG = 70;
  localparam int K_IB = 82;
  localparam int K_QR = 54;
  localparam int K_QG = 134;
  localparam int K_QB = 80;

  localparam logic [23:0] DEF_PHASE_INC   = 24'd2403537;
  localparam logic [7:0]  DEF_LUMA_GAIN   = 8'd45;
  localparam logic [7:0]  DEF_BURST_AMP   = 8'd12;
  localparam logic [5:0]  LVL_BLANK       = 6'd18;
  localparam logic [5:0]  LVL_CHROMA_ZERO = 6'd32;
  localparam logic [5:0]  LVL_SYNC        = 6'd0;

`ifdef COMPOSITE_CHROMA_FILTER_EN
  localparam int unsigned PIPE_LAT = 5;
`else
  localparam int unsigned PIPE_LAT = 4;
`endif

  typedef struct packed {
    logic active;
    logic burst;
    logic sync_n;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{active: 1'b0, burst: 1'b0, sync_n: 1'b1};

  function automatic logic [5:0] sat6(input logic signed [31:0] v);
    if (v < 0)  return '0;
    if (v > 63) return '1;
    return v[5:0];
  endfunction

endpackage

// File: rtl/composite_sin_lut.sv
// Registered sin/cos lookup: 64-entry quarter-wave ROM mirrored to 256 points, amplitude 127.
module composite_sin_lut (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_idx,
  output logic signed [7:0] o_sin,
  output logic signed [7:0] o_cos
);

  localparam logic [6:0] QW [64] = '{
      7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
      7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
      7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
      7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
      7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127};

  // Quadrant 1 mirrors as 64-k; k=64 (the 90 degree point) lies past the ROM and is the peak
  function automatic logic signed [7:0] sin_at(input logic [7:0] k);
    logic [6:0] m;
    logic [6:0] mag;
    m   = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    mag = m[6] ? 7'd127 : QW[m[5:0]];
    return k[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic [7:0] w_cos_idx;
  assign w_cos_idx = i_idx + 8'd64;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sin <= '0;
      o_cos <= '0;
    end else begin
      o_sin <= sin_at(i_idx);
      o_cos <= sin_at(w_cos_idx);
    end
  end

endmodule

// File: rtl/composite_encoder.sv
// NTSC composite encoder: per-clock RGB + timing -> 6-bit luma/chroma DAC codes.
// Define COMPOSITE_CHROMA_FILTER_EN to add a [1 2 1]/4 I/Q low-pass stage (latency 5).
module composite_encoder
  import composite_pkg::*;
#(
  parameter logic [23:0] PHASE_INC   = DEF_PHASE_INC,
  parameter logic [5:0]  BLANK_LEVEL = LVL_BLANK,
  parameter logic [7:0]  LUMA_GAIN   = DEF_LUMA_GAIN,
  parameter logic [7:0]  BURST_AMP   = DEF_BURST_AMP,
  parameter logic [5:0]  CHROMA_ZERO = LVL_CHROMA_ZERO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] r,
  input  logic [3:0] g,
  input  logic [3:0] b,
  input  logic       active,
  input  logic       color_burst,
  input  logic       sync_n,
  output logic [5:0] luma,
  output logic [5:0] chroma
);

  logic [23:0]        r_phase;
  logic [3:0]         r_r, r_g, r_b;
  logic [11:0]        r_ysum, r_y3;
  logic signed [12:0] r_i, r_q, r_i3, r_q3;
  ctrl_t              r_ctl [PIPE_LAT-1];

  logic [11:0]        w_ysum, w_yc;
  logic signed [12:0] w_i, w_q, w_ic, w_qc;
  logic signed [7:0]  w_sin, w_cos;
  logic signed [21:0] w_c;
  logic signed [31:0] w_luma_act, w_chroma_act, w_burst;
  logic [5:0]         w_luma, w_chroma;
  ctrl_t              w_ctl_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= '0;
    else     r_phase <= r_phase + PHASE_INC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < PIPE_LAT-1; j++) r_ctl[j] <= CTRL_RST;
    end else begin
      r_ctl[0] <= '{active: active, burst: color_burst, sync_n: sync_n};
      for (int unsigned j = 1; j < PIPE_LAT-1; j++) r_ctl[j] <= r_ctl[j-1];
    end
  end

  always_comb begin
    w_ysum = 12'(K_YR*int'(r_r) + K_YG*int'(r_g) + K_YB*int'(r_b));
    w_i    = 13'(K_IR*int'(r_r) - K_IG*int'(r_g) - K_IB*int'(r_b));
    w_q    = 13'(K_QR*int'(r_r) - K_QG*int'(r_g) + K_QB*int'(r_b));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_ysum <= '0;
      r_i    <= '0;
      r_q    <= '0;
    end else begin
      r_r    <= r;
      r_g    <= g;
      r_b    <= b;
      r_ysum <= w_ysum;
      r_i    <= w_i;
      r_q    <= w_q;
    end
  end

`ifdef COMPOSITE_CHROMA_FILTER_EN
  logic signed [12:0] r_ih1, r_ih2, r_qh1, r_qh2, r_if, r_qf;
  logic [11:0]        r_yf;

  // r_ctl[1] is the control word travelling alongside r_i/r_q at this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ih1 <= '0;
      r_ih2 <= '0;
      r_qh1 <= '0;
      r_qh2 <= '0;
      r_if  <= '0;
      r_qf  <= '0;
      r_yf  <= '0;
    end else begin
      r_if <= 13'((int'(r_i) + 2*int'(r_ih1) + int'(r_ih2)) >>> 2);
      r_qf <= 13'((int'(r_q) + 2*int'(r_qh1) + int'(r_qh2)) >>> 2);
      r_yf <= r_ysum;
      if (r_ctl[1].active) begin
        r_ih1 <= r_i;
        r_ih2 <= r_ih1;
        r_qh1 <= r_q;
        r_qh2 <= r_qh1;
      end else begin
        r_ih1 <= '0;
        r_ih2 <= '0;
        r_qh1 <= '0;
        r_qh2 <= '0;
      end
    end
  end

  assign w_ic = r_if;
  assign w_qc = r_qf;
  assign w_yc = r_yf;
`else
  assign w_ic = r_i;
  assign w_qc = r_q;
  assign w_yc = r_ysum;
`endif

  composite_sin_lut u_lut (
    .clk   (clk),
    .rst   (rst),
    .i_idx (r_phase[23:16]),
    .o_sin (w_sin),
    .o_cos (w_cos)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y3 <= '0;
      r_i3 <= '0;
      r_q3 <= '0;
    end else begin
      r_y3 <= w_yc;
      r_i3 <= w_ic;
      r_q3 <= w_qc;
    end
  end

  always_comb begin
    w_ctl_o      = r_ctl[PIPE_LAT-2];
    w_c          = 22'(int'(r_i3)*int'(w_cos) + int'(r_q3)*int'(w_sin));
    w_luma_act   = int'(BLANK_LEVEL) + ((int'(r_y3) * int'(LUMA_GAIN)) >>> 12);
    w_chroma_act = int'(CHROMA_ZERO) + int'(w_c >>> 14);
    w_burst      = int'(CHROMA_ZERO) - ((int'(BURST_AMP) * int'(w_sin)) >>> 7);
    w_luma       = BLANK_LEVEL;
    w_chroma     = CHROMA_ZERO;
    if (!w_ctl_o.sync_n)     w_luma = LVL_SYNC;
    else if (w_ctl_o.active) w_luma = sat6(w_luma_act);
    if (w_ctl_o.active)      w_chroma = sat6(w_chroma_act);
    else if (w_ctl_o.burst)  w_chroma = sat6(w_burst);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      luma   <= '0;
      chroma <= CHROMA_ZERO;
    end else begin
      luma   <= w_luma;
      chroma <= w_chroma;
    end
  end

endmodule
